// File: rtl/dsp_mult_acc.sv
// Three-stage pipelined multiply/accumulate tile with a valid/ready handshake and a sticky overflow flag.
// Optional build macro: DSP_MULT_ACC_SATURATE_EN (clamp on overflow instead of wrapping).
module dsp_mult_acc #(
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 9,
  parameter int ACC_WIDTH = 24,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 acc_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] y,
  output logic                 ovf
);

  localparam int PW = ACC_WIDTH + 1;
  localparam bit SIGNED_MODE = (A_SIGNED != 0) || (B_SIGNED != 0);

  logic adv, accept, s3_load;

  logic               s1_valid_q, s1_valid_d;
  logic [A_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0] s1_b_q, s1_b_d;
  logic               s1_acc_q, s1_acc_d;

  logic          s2_valid_q, s2_valid_d;
  logic [PW-1:0] s2_prod_q, s2_prod_d;
  logic          s2_acc_q, s2_acc_d;

  logic [ACC_WIDTH-1:0] y_q, y_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic                 a_sign, b_sign, y_sign, overflow;
  logic signed [PW-1:0] a_ext, b_ext, prod_full;
  logic [PW-1:0]        y_ext, sum;

  always_comb begin
    adv     = !out_valid_q || out_ready;
    accept  = in_valid && adv;
    s3_load = adv && s2_valid_q;
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_acc_d   = s1_acc_q;
    if (adv) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_a_d   = a;
      s1_b_d   = b;
      s1_acc_d = acc_en;
    end
  end

  // Operands widened to the sum width; the true product always fits, so truncation is exact.
  always_comb begin
    a_sign    = (A_SIGNED != 0) && s1_a_q[A_WIDTH-1];
    b_sign    = (B_SIGNED != 0) && s1_b_q[B_WIDTH-1];
    a_ext     = {{(PW-A_WIDTH){a_sign}}, s1_a_q};
    b_ext     = {{(PW-B_WIDTH){b_sign}}, s1_b_q};
    prod_full = a_ext * b_ext;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_acc_d   = s2_acc_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d = prod_full;
        s2_acc_d  = s1_acc_q;
      end
    end
  end

  always_comb begin
    y_sign   = SIGNED_MODE && y_q[ACC_WIDTH-1];
    y_ext    = {y_sign, y_q};
    sum      = y_ext + s2_prod_q;
    overflow = SIGNED_MODE ? (sum[PW-1] != sum[PW-2]) : sum[PW-1];
    y_d         = y_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (s3_load) begin
      out_valid_d = 1'b1;
      if (!s2_acc_q) begin
        y_d   = s2_prod_q[ACC_WIDTH-1:0];
        ovf_d = 1'b0;
      end else begin
        y_d = sum[ACC_WIDTH-1:0];
        if (overflow) begin
          ovf_d = 1'b1;
`ifdef DSP_MULT_ACC_SATURATE_EN
          // The extra sum bit tells which limit was crossed.
          if (!SIGNED_MODE) begin
            y_d = {ACC_WIDTH{1'b1}};
          end else if (sum[PW-1]) begin
            y_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
          end else begin
            y_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
          end
`else
          y_d = sum[ACC_WIDTH-1:0];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_acc_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_acc_q    <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_acc_q    <= s1_acc_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_acc_q    <= s2_acc_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
